// File: rtl/mem_req_demux_if.sv
// CPU request/response and two-target bus bundle for mem_req_demux.
// slave is the router's view; master is the CPU-plus-targets side.
interface mem_req_demux_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              t0_valid;
    logic              t0_we;
    logic [ADDR_W-1:0] t0_addr;
    logic [DATA_W-1:0] t0_wdata;
    logic              t0_ack;
    logic [DATA_W-1:0] t0_rdata;
    logic              t1_valid;
    logic              t1_we;
    logic [ADDR_W-1:0] t1_addr;
    logic [DATA_W-1:0] t1_wdata;
    logic              t1_ack;
    logic [DATA_W-1:0] t1_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output t0_valid, t0_we, t0_addr, t0_wdata,
        input  t0_ack, t0_rdata,
        output t1_valid, t1_we, t1_addr, t1_wdata,
        input  t1_ack, t1_rdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  t0_valid, t0_we, t0_addr, t0_wdata,
        output t0_ack, t0_rdata,
        input  t1_valid, t1_we, t1_addr, t1_wdata,
        output t1_ack, t1_rdata
    );
endinterface

// File: rtl/mem_req_demux.sv
// Registered 1-to-2 request router: data RAM (target 0) / MMIO (target 1),
// one outstanding request, single-cycle response, BUSY timeout.
module mem_req_demux #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] SPLIT_BASE = 'h8000,
    parameter int unsigned       TIMEOUT    = 16
) (
    input  logic            clk,
    input  logic            rst,
    mem_req_demux_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, RESP} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              t0_valid_q, t1_valid_q, rsp_valid_q, ready_q;
    logic              sel_ack;
    logic [DATA_W-1:0] sel_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            t0_valid_q  <= 1'b0;
            t1_valid_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            // Strobes are flopped from the next state so they leave the block glitch-free.
            t0_valid_q  <= (state_d == BUSY0);
            t1_valid_q  <= (state_d == BUSY1);
            rsp_valid_q <= (state_d == RESP);
            ready_q     <= (state_d == IDLE);
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        sel_ack   = (state_q == BUSY0) ? bus.t0_ack   : bus.t1_ack;
        sel_rdata = (state_q == BUSY0) ? bus.t0_rdata : bus.t1_rdata;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    state_d = (bus.req_addr >= SPLIT_BASE) ? BUSY1 : BUSY0;
                end
            end
            BUSY0, BUSY1: begin
                // An ack on the last allowed cycle beats the timeout.
                if (sel_ack) begin
                    rdata_d = we_q ? '0 : sel_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.t0_valid  = t0_valid_q;
    assign bus.t0_we     = we_q;
    assign bus.t0_addr   = addr_q;
    assign bus.t0_wdata  = wdata_q;
    assign bus.t1_valid  = t1_valid_q;
    assign bus.t1_we     = we_q;
    assign bus.t1_addr   = addr_q;
    assign bus.t1_wdata  = wdata_q;
endmodule

// File: tb/tb_mem_req_demux.sv
// Self-checking bench for mem_req_demux: vector table with a response
// scoreboard, plus reset-in-BUSY and back-to-back sequences.
module tb_mem_req_demux;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] trdata;
        logic        spur;
        logic        tgt;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_nv;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    localparam int NO_ACK = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;
    rsp_t exp_q[$];
    vec_t vecs[8];

    mem_req_demux_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_req_demux #(
        .ADDR_W(32), .DATA_W(32), .SPLIT_BASE(32'h0000_8000), .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every response strobe must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 required none at %0t", $time);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int   guard;
        int   nv;
        bit   done;
        logic sv, ov;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready_wait"}, 32'(guard < 50), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        exp_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        @(negedge clk);
        bus.req_valid = 1'b0;
        nv   = 0;
        done = 1'b0;
        while (!done && nv < 300) begin
            sv = v.tgt ? bus.t1_valid : bus.t0_valid;
            ov = v.tgt ? bus.t0_valid : bus.t1_valid;
            if (sv !== 1'b1) begin
                done = 1'b1;
            end else begin
                nv++;
                check({tag, "_other_valid"}, 32'(ov), 32'd0);
                check({tag, "_addr"},  v.tgt ? bus.t1_addr  : bus.t0_addr,  v.addr);
                check({tag, "_wdata"}, v.tgt ? bus.t1_wdata : bus.t0_wdata, v.wdata);
                check({tag, "_we"}, 32'(v.tgt ? bus.t1_we : bus.t0_we), 32'(v.we));
                if (v.spur) begin
                    if (v.tgt) begin bus.t0_ack = 1'b1; bus.t0_rdata = 32'hBAD0BAD0; end
                    else       begin bus.t1_ack = 1'b1; bus.t1_rdata = 32'hBAD0BAD0; end
                end
                if (nv - 1 == v.dly) begin
                    if (v.tgt) begin bus.t1_ack = 1'b1; bus.t1_rdata = v.trdata; end
                    else       begin bus.t0_ack = 1'b1; bus.t0_rdata = v.trdata; end
                end
                @(negedge clk);
                bus.t0_ack = 1'b0;
                bus.t1_ack = 1'b0;
            end
        end
        check({tag, "_valid_cycles"}, 32'(nv), 32'(v.exp_nv));
        check({tag, "_rsp_timing"}, 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_rsp_one_cycle"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int  nv;
        int  k;
        int  acc_at[3];
        bit  acc;
        bit  t1_seen;
        logic [31:0] a;

        //            we    addr          wdata         dly     trdata        spur  tgt   exp_rdata     err   nv
        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,        0,      32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1};
        vecs[1] = '{1'b1, 32'h0000_8004, 32'h12345678, 3,      32'hFFFFFFFF, 1'b0, 1'b1, 32'h0,        1'b0, 4};
        vecs[2] = '{1'b0, 32'h0000_7FFC, 32'h0,        1,      32'h11112222, 1'b0, 1'b0, 32'h11112222, 1'b0, 2};
        vecs[3] = '{1'b0, 32'h0000_9000, 32'h0,        NO_ACK, 32'h0,        1'b1, 1'b1, 32'h0,        1'b1, 16};
        vecs[4] = '{1'b0, 32'h0000_8000, 32'h0,        15,     32'hA5A5A5A5, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 16};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0,        2,      32'h0BADF00D, 1'b0, 1'b1, 32'h0BADF00D, 1'b0, 3};
        vecs[6] = '{1'b1, 32'h0000_0000, 32'h55AA55AA, NO_ACK, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 16};
        vecs[7] = '{1'b0, 32'h0000_0100, 32'h0,        0,      32'h600DCAFE, 1'b0, 1'b0, 32'h600DCAFE, 1'b0, 1};

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.t0_ack = 1'b0; bus.t0_rdata = '0; bus.t1_ack = 1'b0; bus.t1_rdata = '0;

        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
        check("rst_t0_valid",  32'(bus.t0_valid), 32'd0);
        check("rst_t1_valid",  32'(bus.t1_valid), 32'd0);
        check("rst_t0_addr",   bus.t0_addr, 32'h0);
        check("rst_t1_wdata",  bus.t1_wdata, 32'h0);
        check("rst_t1_we",     32'(bus.t1_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while BUSY0: valid must drop asynchronously and no response appears.
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h20;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rb_t0_valid", 32'(bus.t0_valid), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rb_t0_valid_async", 32'(bus.t0_valid), 32'd0);
        check("rb_t0_addr_async", bus.t0_addr, 32'h0);
        @(negedge clk);
        check("rb_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rb_rsp_valid_after", 32'(bus.rsp_valid), 32'd0);
        check("rb_ready_after", 32'(bus.req_ready), 32'd1);
        run_vec(vecs[7], "post_rst");

        // Back-to-back loads with req_valid held and first-cycle acks.
        nv = 0; k = 0; t1_seen = 1'b0;
        a = 32'h200;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a;
        exp_q.push_back('{rdata: a ^ 32'hCAFE0000, err: 1'b0});
        for (int c = 0; c < 9; c++) begin
            bus.t0_ack   = bus.t0_valid;
            bus.t0_rdata = bus.t0_addr ^ 32'hCAFE0000;
            if (bus.t0_valid === 1'b1) nv++;
            if (bus.t1_valid === 1'b1) t1_seen = 1'b1;
            acc = (bus.req_ready === 1'b1) && bus.req_valid && (k < 3);
            if (acc) acc_at[k] = c;
            @(negedge clk);
            if (acc) begin
                k++;
                if (k < 3) begin
                    a = 32'h200 + 32'(4 * k);
                    bus.req_addr = a;
                    exp_q.push_back('{rdata: a ^ 32'hCAFE0000, err: 1'b0});
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        bus.t0_ack = 1'b0;
        check("b2b_accepts", 32'(k), 32'd3);
        check("b2b_gap01", 32'(acc_at[1] - acc_at[0]), 32'd3);
        check("b2b_gap12", 32'(acc_at[2] - acc_at[1]), 32'd3);
        check("b2b_t0_valid_cycles", 32'(nv), 32'd3);
        check("b2b_t1_never", 32'(t1_seen), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
